// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers pixel coordinates from hsync/vsync
// edges, checks line/frame periods and tracks lock status.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_PULSE     = 96,
  parameter int H_BP        = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 521,
  parameter int V_BP        = 31,
  parameter int V_ACTIVE    = 480,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_cnt
);

  localparam logic        ACT       = (SYNC_POL != 0);
  localparam logic [9:0]  H_END     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_PW_END  = 10'(H_PULSE - 1);
  localparam logic [9:0]  V_END     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_OFF     = 10'(H_BP);
  localparam logic [9:0]  V_OFF     = 10'(V_BP);
  localparam logic [10:0] H_LO      = 11'(H_BP);
  localparam logic [10:0] H_HI      = 11'(H_BP + H_ACTIVE);
  localparam logic [10:0] V_LO      = 11'(V_BP);
  localparam logic [10:0] V_HI      = 11'(V_BP + V_ACTIVE);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FRAMES - 1);
  localparam logic [9:0]  CNT_MAX   = 10'd1023;
  localparam logic [9:0]  CNT_PRE   = 10'd1022;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state;
  logic       hs_q, vs_q;
  logic [9:0] hcnt, vcnt;
  logic       h_first;
  logic       h_seen;
  logic [7:0] good;

  logic hs_on, vs_on, hs_lead, hs_trail, vs_lead;
  logic h_bad, v_bad, h_win, v_win, in_win;

  assign hs_on    = (hsync == ACT);
  assign vs_on    = (vsync == ACT);
  assign hs_lead  = hs_on && (hs_q != ACT);
  assign hs_trail = !hs_on && (hs_q == ACT);
  assign vs_lead  = vs_on && (vs_q != ACT);

  // The first hsync edge after reset/SEARCH and the first vsync edge seen in
  // SEARCH have no previous edge to be measured against.
  assign h_bad = (hs_lead && !h_first && hcnt != H_END)
              || (hs_trail && hcnt != H_PW_END)
              || (!hs_lead && hcnt == CNT_PRE);
  assign v_bad = (vs_lead && state != SEARCH && vcnt != V_END)
              || (!vs_lead && hs_lead && vcnt == CNT_PRE);

  assign h_win  = ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} < H_HI);
  assign v_win  = ({1'b0, vcnt} >= V_LO) && ({1'b0, vcnt} < V_HI);
  assign in_win = locked && h_win && v_win;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hs_q    <= ~ACT;
      vs_q    <= ~ACT;
      hcnt    <= '0;
      vcnt    <= '0;
      h_first <= 1'b1;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      if (hs_lead)
        hcnt <= '0;
      else if (hcnt != CNT_MAX)
        hcnt <= hcnt + 10'd1;
      if (vs_lead)
        vcnt <= '0;
      else if (hs_lead && vcnt != CNT_MAX)
        vcnt <= vcnt + 10'd1;
      if (state == LOCKED && (h_err || v_err))
        h_first <= 1'b1;
      else if (hs_lead)
        h_first <= 1'b0;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      err_cnt     <= '0;
    end else begin
      active      <= in_win;
      x           <= in_win ? hcnt - H_OFF : '0;
      y           <= in_win ? vcnt - V_OFF : '0;
      frame_start <= vs_lead;
      h_err       <= h_bad;
      v_err       <= v_bad;
      if ((h_bad || v_bad) && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  // Lock tracking runs off the registered pulses, so locked follows an error
  // pulse by one cycle.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state  <= SEARCH;
      locked <= 1'b0;
      good   <= '0;
      h_seen <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          good   <= '0;
          h_seen <= 1'b0;
          if (frame_start)
            state <= ACQUIRE;
        end
        ACQUIRE: begin
          if (frame_start) begin
            h_seen <= 1'b0;
            if (h_err || v_err || h_seen) begin
              good <= '0;
            end else if (good == LOCK_LAST) begin
              good   <= '0;
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              good <= good + 8'd1;
            end
          end else if (h_err || v_err) begin
            good   <= '0;
            h_seen <= 1'b1;
          end
        end
        LOCKED: begin
          if (h_err || v_err) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor: nominal 800-clock lines with a short
// 6-line frame so several lock/relock cycles fit in a short run.
module tb_vga_sync_monitor;

  localparam int HT = 800;
  localparam int HP = 96;
  localparam int HB = 144;
  localparam int HA = 640;
  localparam int VT = 6;
  localparam int VB = 2;
  localparam int VA = 3;
  localparam int FRAME_LIMIT = 3 * HT * VT + 2000;

  logic       dclk = 1'b0;
  logic       clr = 1'b1;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] x, y;
  logic       active, frame_start, locked, h_err, v_err;
  logic [7:0] err_cnt;

  int tests = 0;
  int failed = 0;
  int gh = 0, gv = 0;
  int llen = HT, hpw = HP, flen = VT;
  bit hold = 1'b0;
  int herr_seen = 0, verr_seen = 0, fs_seen = 0;

  typedef struct {
    int line;
    int pix;
    int ex;
    int ey;
    int eact;
  } vec_t;

  vec_t vecs[9];

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_PULSE(HP), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_BP(VB), .V_ACTIVE(VA),
    .SYNC_POL(0), .LOCK_FRAMES(2)
  ) dut (
    .dclk(dclk), .clr(clr), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .active(active), .frame_start(frame_start),
    .locked(locked), .h_err(h_err), .v_err(v_err), .err_cnt(err_cnt)
  );

  always #5 dclk = ~dclk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests++;
    failed++;
    $display("[TB] FAIL %s: wait expired at line %0d pix %0d", name, gv, gh);
  endtask

  // One pixel clock of the reference generator; outputs are sampled 1 ns after
  // the edge, so they belong to the new (gv, gh) position.
  task automatic step();
    if (hold) begin
      hsync = 1'b1;
      vsync = 1'b1;
    end else begin
      hsync = (gh < hpw) ? 1'b0 : 1'b1;
      vsync = (gv < 2) ? 1'b0 : 1'b1;
    end
    @(posedge dclk);
    #1;
    if (!hold) begin
      gh++;
      if (gh >= llen) begin
        gh = 0;
        gv++;
        if (gv >= flen) gv = 0;
      end
    end
    herr_seen += int'(h_err);
    verr_seen += int'(v_err);
    fs_seen   += int'(frame_start);
  endtask

  task automatic applyStimulus(input int line, input int pix, input int limit);
    int n = 0;
    while (!(gv == line && gh == pix) && n < limit) begin
      step();
      n++;
    end
    if (!(gv == line && gh == pix)) timeoutFail("reach position");
  endtask

  task automatic waitFs(input int target, input int limit);
    int n = 0;
    while (fs_seen < target && n < limit) begin
      step();
      n++;
    end
    if (fs_seen < target) timeoutFail("frame_start count");
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL global timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base, hb, vb;

    vecs[0] = '{1, 300,   0, 0, 0};
    vecs[1] = '{2, 145,   0, 0, 0};
    vecs[2] = '{2, 146,   0, 0, 1};
    vecs[3] = '{2, 147,   1, 0, 1};
    vecs[4] = '{3, 400, 254, 1, 1};
    vecs[5] = '{4, 146,   0, 2, 1};
    vecs[6] = '{4, 785, 639, 2, 1};
    vecs[7] = '{4, 786,   0, 0, 0};
    vecs[8] = '{5, 200,   0, 0, 0};

    repeat (3) @(posedge dclk);
    #1;
    checkOutput("reset x", int'(x), 0);
    checkOutput("reset y", int'(y), 0);
    checkOutput("reset active", int'(active), 0);
    checkOutput("reset frame_start", int'(frame_start), 0);
    checkOutput("reset locked", int'(locked), 0);
    checkOutput("reset h_err", int'(h_err), 0);
    checkOutput("reset v_err", int'(v_err), 0);
    checkOutput("reset err_cnt", int'(err_cnt), 0);
    clr = 1'b0;

    waitFs(2, FRAME_LIMIT);
    step();
    checkOutput("locked after 2nd edge", int'(locked), 0);
    waitFs(3, FRAME_LIMIT);
    checkOutput("locked at 3rd edge", int'(locked), 0);
    step();
    checkOutput("locked after 3rd edge", int'(locked), 1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].line, vecs[i].pix, HT * VT);
      checkOutput($sformatf("x @%0d/%0d", vecs[i].line, vecs[i].pix), int'(x), vecs[i].ex);
      checkOutput($sformatf("y @%0d/%0d", vecs[i].line, vecs[i].pix), int'(y), vecs[i].ey);
      checkOutput($sformatf("active @%0d/%0d", vecs[i].line, vecs[i].pix), int'(active), vecs[i].eact);
    end
    checkOutput("nominal h_err count", herr_seen, 0);
    checkOutput("nominal v_err count", verr_seen, 0);
    checkOutput("nominal err_cnt", int'(err_cnt), 0);

    // one 799-clock line while locked
    applyStimulus(1, 10, HT * VT);
    llen = HT - 1;
    applyStimulus(2, 0, HT);
    llen = HT;
    step();
    checkOutput("short line h_err", int'(h_err), 1);
    checkOutput("short line err_cnt", int'(err_cnt), 1);
    checkOutput("short line locked same cycle", int'(locked), 1);
    step();
    checkOutput("short line locked dropped", int'(locked), 0);
    checkOutput("short line h_err pulse width", int'(h_err), 0);
    checkOutput("short line h_err total", herr_seen, 1);

    base = fs_seen;
    waitFs(base + 2, FRAME_LIMIT);
    step();
    checkOutput("relock not yet", int'(locked), 0);
    waitFs(base + 3, FRAME_LIMIT);
    step();
    checkOutput("relock after 3 edges", int'(locked), 1);
    checkOutput("relock err_cnt", int'(err_cnt), 1);

    // asynchronous clear mid-frame while locked
    applyStimulus(3, 400, HT * VT);
    checkOutput("pre-clear active", int'(active), 1);
    #2 clr = 1'b1;
    #1;
    checkOutput("clear x", int'(x), 0);
    checkOutput("clear active", int'(active), 0);
    checkOutput("clear locked", int'(locked), 0);
    checkOutput("clear err_cnt", int'(err_cnt), 0);
    repeat (3) step();
    clr = 1'b0;
    hb = herr_seen;
    base = fs_seen;
    waitFs(base + 2, FRAME_LIMIT);
    step();
    checkOutput("post-clear not locked", int'(locked), 0);
    waitFs(base + 3, FRAME_LIMIT);
    step();
    checkOutput("post-clear relock", int'(locked), 1);
    checkOutput("post-clear h_err count", herr_seen - hb, 0);

    // 95-clock hsync pulse while locked
    applyStimulus(1, 200, HT * VT);
    hpw = HP - 1;
    applyStimulus(2, 96, HT);
    hpw = HP;
    checkOutput("narrow pulse h_err", int'(h_err), 1);
    checkOutput("narrow pulse err_cnt", int'(err_cnt), 1);
    step();
    checkOutput("narrow pulse lock lost", int'(locked), 0);

    // short frame whose last line is also short: coincident h_err and v_err
    base = fs_seen;
    waitFs(base + 1, FRAME_LIMIT);
    flen = VT - 1;
    applyStimulus(4, 10, HT * VT);
    llen = HT - 1;
    applyStimulus(0, 0, HT);
    llen = HT;
    flen = VT;
    vb = verr_seen;
    step();
    checkOutput("coincident h_err", int'(h_err), 1);
    checkOutput("coincident v_err", int'(v_err), 1);
    checkOutput("coincident err_cnt", int'(err_cnt), 2);
    step();
    checkOutput("coincident err_cnt hold", int'(err_cnt), 2);
    checkOutput("coincident v_err total", verr_seen - vb, 1);

    // hsync idle long enough for hcnt to saturate
    applyStimulus(3, 200, HT * VT);
    hold = 1'b1;
    hb = herr_seen;
    repeat (2000) step();
    hold = 1'b0;
    checkOutput("idle h_err pulses", herr_seen - hb, 1);
    checkOutput("idle err_cnt", int'(err_cnt), 3);
    applyStimulus(4, 1, HT);
    checkOutput("edge after idle h_err", int'(h_err), 1);
    checkOutput("edge after idle err_cnt", int'(err_cnt), 4);

    // toggle hsync every clock to flood the error counter
    for (int i = 0; i < 400; i++) begin
      hsync = (i % 2 == 0) ? 1'b0 : 1'b1;
      vsync = 1'b1;
      @(posedge dclk);
      #1;
    end
    checkOutput("flood h_err", int'(h_err), 1);
    checkOutput("err_cnt saturated", int'(err_cnt), 255);
    for (int i = 0; i < 6; i++) begin
      hsync = (i % 2 == 0) ? 1'b0 : 1'b1;
      @(posedge dclk);
      #1;
    end
    checkOutput("err_cnt holds at 255", int'(err_cnt), 255);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator: samples the generated hsync/vsync pair on the pixel clock and recovers the pixel coordinates and active-video flag from the sync edges alone.
- Checks line and frame periods against nominal timing and reports lock and error status.
- Sits beside the VGA controller on dclk as an on-chip timing checker. Its x/y/active outputs also give downstream pixel logic (Pong objects) a sync-derived coordinate source.

Parameters:
- H_TOTAL, 800, pixel clocks per line
- H_PULSE, 96, hsync pulse width in clocks
- H_BP, 144, first active clock, counted from the hsync leading edge
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 521, lines per frame
- V_BP, 31, first active line, counted from the vsync leading edge
- V_ACTIVE, 480, active lines per frame
- SYNC_POL, 0, active level of both syncs (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
- dclk  in  1  pixel clock (25 MHz); the block has this one clock only
- clr  in  1  reset; asynchronous, active-high
- hsync  in  1  horizontal sync from the generator, synchronous to dclk
- vsync  in  1  vertical sync from the generator, synchronous to dclk
- x  out  10  recovered column, 0..639; 0 outside active video
- y  out  10  recovered row, 0..479; 0 outside active video
- active  out  1  in active region and locked
- frame_start  out  1  1-cycle pulse on each vsync leading edge
- locked  out  1  timing lock status
- h_err  out  1  1-cycle pulse on a horizontal timing violation
- v_err  out  1  1-cycle pulse on a vertical timing violation
- err_cnt  out  8  saturating error count (h_err or v_err events)

Behaviour:
- Reset (clr high, async): all counters 0, sample registers hold the inactive sync level, FSM = SEARCH. All outputs 0 (x, y, active, frame_start, locked, h_err, v_err, err_cnt).
- Edge detection: hs_q and vs_q register the inputs each cycle. A leading edge in cycle t means the input is at the active level at t and was inactive at t-1. Trailing edge is the reverse.
- hcnt, 10 bits:
  - Loads 0 on an hsync leading edge; otherwise increments, saturating at 1023.
  - With a conforming input, hcnt equals H_PULSE-1 at the trailing edge and H_TOTAL-1 at the next leading edge.
- vcnt, 10 bits:
  - Loads 0 on a vsync leading edge; otherwise increments on each hsync leading edge, saturating at 1023.
  - If both leading edges fall in the same cycle, the vsync load wins.
- h_err pulses on any of:
  - hsync leading edge with hcnt != H_TOTAL-1 (first leading edge after reset/SEARCH exempt)
  - hsync trailing edge with hcnt != H_PULSE-1
  - hcnt reaching 1023
- v_err pulses on a vsync leading edge with vcnt != V_TOTAL-1 (first edge after SEARCH exempt), or when vcnt reaches 1023.
- Simultaneous h_err and v_err increment err_cnt by 1 only. err_cnt holds at 255.
- Lock FSM:
  - SEARCH: on the first vsync leading edge, go to ACQUIRE with good = 0.
  - ACQUIRE: a frame is good if the next vsync leading edge brings no v_err and there was no h_err since the previous one. Each good frame increments good. When good reaches LOCK_FRAMES, go to LOCKED. Any error clears good and stays in ACQUIRE.
  - LOCKED: locked = 1. Any h_err/v_err goes to SEARCH (locked drops the cycle after the error pulse).
- Outputs, registered, 1-cycle latency from the counters:
  - active = locked && H_BP <= hcnt < H_BP+H_ACTIVE && V_BP <= vcnt < V_BP+V_ACTIVE
  - x = hcnt-H_BP and y = vcnt-V_BP when active, else 0
  - frame_start = registered vsync leading edge, in every FSM state
- Arithmetic is unsigned, 10 bits. Subtractions are only evaluated inside the active window, so no wrap.
- Reset mid-frame: immediate return to reset state. Lock must be re-earned (first edges exempt, then LOCK_FRAMES good frames).

Test Plan:
- Nominal stream, 800x521, 96-clk hsync, 2-line vsync, active-low -> locked rises at the 3rd vsync leading edge after reset. h_err = v_err = 0, err_cnt = 0. At hcnt = 144, vcnt = 31: x = 0, y = 0, active = 1 one cycle later. At hcnt = 783, vcnt = 510: x = 639, y = 479. hcnt = 784 -> active = 0.
- Locked, one line shortened to 799 clocks -> single h_err pulse, locked = 0 next cycle, err_cnt = 1, FSM SEARCH. Relock after 3 further vsync edges.
- Locked, hsync pulse 95 clocks wide -> h_err at the trailing edge, err_cnt increments, lock lost.
- Frame of 520 lines -> v_err at the vsync leading edge. With the line-length fault injected in the same frame, the coincident h_err and v_err raise err_cnt by exactly 1.
- hsync held inactive for 2000 clocks -> h_err when hcnt hits 1023, hcnt stays 1023, and no further h_err pulses until a new leading edge.
- clr pulsed mid-frame while locked -> all outputs 0 asynchronously. After release, locked stays 0 until the 3rd vsync edge. 300 injected errors -> err_cnt = 255.
